// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the core hazard/stall controller: per-stage control encoding,
// controller states and the load opcode used by the load-use compare.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      CTRL_DEFAULT = 2'b00,
      CTRL_BLOCK   = 2'b01,
      CTRL_BUBBLE  = 2'b10
   } ctrl_state_e;

   typedef enum logic [1:0] {
      PCTRL_RUN      = 2'b00,
      PCTRL_MEM_WAIT = 2'b01,
      PCTRL_FLUSH    = 2'b10
   } pctrl_state_e;

   localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

   typedef struct packed {
      ctrl_state_e if_id;
      ctrl_state_e id_ex;
      ctrl_state_e ex_mem;
      ctrl_state_e mem_wb;
   } stage_ctrl_t;

   function automatic stage_ctrl_t all_ctrl(input ctrl_state_e s);
      return '{if_id: s, id_ex: s, ex_mem: s, mem_wb: s};
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline stages and per-stage control outputs of the controller.
// master = pipeline side, slave = controller side.
interface pipeline_ctrl_if;
   logic [4:0] id_rs1_addr_i;
   logic [4:0] id_rs2_addr_i;
   logic       id_use_rs1_i;
   logic       id_use_rs2_i;
   logic [6:0] ex_opcode_i;
   logic [4:0] ex_rd_addr_i;
   logic       ex_wreg_i;
   logic       ex_branch_taken_i;
   logic       mem_req_valid_i;
   logic       mem_resp_valid_i;
   logic [1:0] if_id_ctrl_o;
   logic [1:0] id_ex_ctrl_o;
   logic [1:0] ex_mem_ctrl_o;
   logic [1:0] mem_wb_ctrl_o;
   logic       pc_wen_o;

   modport master (
      output id_rs1_addr_i, id_rs2_addr_i, id_use_rs1_i, id_use_rs2_i,
             ex_opcode_i, ex_rd_addr_i, ex_wreg_i, ex_branch_taken_i,
             mem_req_valid_i, mem_resp_valid_i,
      input  if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o, pc_wen_o
   );

   modport slave (
      input  id_rs1_addr_i, id_rs2_addr_i, id_use_rs1_i, id_use_rs2_i,
             ex_opcode_i, ex_rd_addr_i, ex_wreg_i, ex_branch_taken_i,
             mem_req_valid_i, mem_resp_valid_i,
      output if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o, pc_wen_o
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare between the instruction in ID and a load in EX; purely combinational.
// Latency 0; no backpressure of its own, the caller decides how to stall.
module pipeline_ctrl_hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [6:0] ex_opcode,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_wreg,
   output logic       load_use
);
   logic ex_load_wr;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired zero, so a load targeting it can never feed a consumer
   assign ex_load_wr = (ex_opcode == OPCODE_LOAD) && ex_wreg && (ex_rd_addr != 5'd0);
   assign rs1_hit    = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
   assign rs2_hit    = id_use_rs2 && (id_rs2_addr == ex_rd_addr);
   assign load_use   = ex_load_wr && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: drives IF_ID/ID_EX/EX_MEM/MEM_WB control and PC write enable.
// Latency 0 (outputs combinational from state); memory waits hold the whole pipe via Block.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 256,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             rst,
   pipeline_ctrl_if.slave   pif,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             mem_timeout_o
);
   localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   pctrl_state_e      state_q;
   pctrl_state_e      state_nxt;
   stage_ctrl_t       ctrl;
   logic              pc_wen;
   logic              load_use;
   logic              mem_stall;
   logic [WAIT_W-1:0] wait_cnt;

   pipeline_ctrl_hazard_detect u_hazard_detect (
      .id_rs1_addr (pif.id_rs1_addr_i),
      .id_rs2_addr (pif.id_rs2_addr_i),
      .id_use_rs1  (pif.id_use_rs1_i),
      .id_use_rs2  (pif.id_use_rs2_i),
      .ex_opcode   (pif.ex_opcode_i),
      .ex_rd_addr  (pif.ex_rd_addr_i),
      .ex_wreg     (pif.ex_wreg_i),
      .load_use    (load_use)
   );

   assign mem_stall = pif.mem_req_valid_i && !pif.mem_resp_valid_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PCTRL_RUN;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      ctrl      = all_ctrl(CTRL_DEFAULT);
      pc_wen    = 1'b1;
      case (state_q)
         PCTRL_RUN: begin
            // memory wins: branch/load-use stay in EX/ID under Block and resurface later
            if (mem_stall) begin
               ctrl        = all_ctrl(CTRL_BLOCK);
               ctrl.mem_wb = CTRL_BUBBLE;
               pc_wen      = 1'b0;
               state_nxt   = PCTRL_MEM_WAIT;
            end else if (pif.ex_branch_taken_i) begin
               ctrl.if_id = CTRL_BUBBLE;
               ctrl.id_ex = CTRL_BUBBLE;
               state_nxt  = PCTRL_FLUSH;
            end else if (load_use) begin
               ctrl.if_id = CTRL_BLOCK;
               ctrl.id_ex = CTRL_BUBBLE;
               pc_wen     = 1'b0;
            end
         end
         PCTRL_MEM_WAIT: begin
            if (pif.mem_resp_valid_i) begin
               state_nxt = PCTRL_RUN;
            end else begin
               ctrl        = all_ctrl(CTRL_BLOCK);
               ctrl.mem_wb = CTRL_BUBBLE;
               pc_wen      = 1'b0;
            end
         end
         PCTRL_FLUSH: begin
            if (mem_stall) begin
               ctrl        = all_ctrl(CTRL_BLOCK);
               ctrl.mem_wb = CTRL_BUBBLE;
               pc_wen      = 1'b0;
               state_nxt   = PCTRL_MEM_WAIT;
            end else begin
               ctrl.if_id = CTRL_BUBBLE;
               state_nxt  = PCTRL_RUN;
            end
         end
         default: begin
            state_nxt = PCTRL_RUN;
         end
      endcase
      // reset forces a quiescent pipe regardless of the state register
      if (!rst) begin
         ctrl   = all_ctrl(CTRL_BUBBLE);
         pc_wen = 1'b0;
      end
   end

   assign pif.if_id_ctrl_o  = ctrl.if_id;
   assign pif.id_ex_ctrl_o  = ctrl.id_ex;
   assign pif.ex_mem_ctrl_o = ctrl.ex_mem;
   assign pif.mem_wb_ctrl_o = ctrl.mem_wb;
   assign pif.pc_wen_o      = pc_wen;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_o <= '0;
      end else if (!pc_wen && (stall_cnt_o != {CNT_W{1'b1}})) begin
         stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end

   // counts only cycles actually spent waiting; the response cycle clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt      <= '0;
         mem_timeout_o <= 1'b0;
      end else if ((state_q == PCTRL_MEM_WAIT) && !pif.mem_resp_valid_i) begin
         if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (wait_cnt == WAIT_MAX - 1'b1) begin
            mem_timeout_o <= 1'b1;
         end
      end else begin
         wait_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a behavioural model of the stall rules.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int TMO   = 8;
   localparam int CW    = 6;
   localparam int SAT   = (1 << CW) - 1;
   localparam logic [6:0] OP_ADDI = 7'h13;

   logic          clk;
   logic          rst;
   logic [CW-1:0] stall_cnt;
   logic          mem_timeout;

   pipeline_ctrl_if pif ();

   pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .pif           (pif),
      .stall_cnt_o   (stall_cnt),
      .mem_timeout_o (mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // model: busy = a memory access is outstanding, flushing = one cycle after a taken branch
   bit busy;
   bit flushing;
   int waited;
   int stalls;
   bit tmo;

   function automatic bit model_load_use();
      if (pif.ex_opcode_i != OPCODE_LOAD || !pif.ex_wreg_i || pif.ex_rd_addr_i == 5'd0)
         return 1'b0;
      return (pif.id_use_rs1_i && pif.id_rs1_addr_i == pif.ex_rd_addr_i) ||
             (pif.id_use_rs2_i && pif.id_rs2_addr_i == pif.ex_rd_addr_i);
   endfunction

   task automatic drive(input bit br, input bit req, input bit resp, input bit ld,
                        input logic [4:0] rd, input bit wreg,
                        input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2);
      pif.ex_branch_taken_i = br;
      pif.mem_req_valid_i   = req;
      pif.mem_resp_valid_i  = resp;
      pif.ex_opcode_i       = ld ? OPCODE_LOAD : OP_ADDI;
      pif.ex_rd_addr_i      = rd;
      pif.ex_wreg_i         = wreg;
      pif.id_rs1_addr_i     = rs1;
      pif.id_rs2_addr_i     = rs2;
      pif.id_use_rs1_i      = u1;
      pif.id_use_rs2_i      = u2;
   endtask

   task automatic quiet();
      drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
   endtask

   // check one cycle against the model, then advance model and clock
   task automatic step();
      int e_if, e_id, e_ex, e_wb, e_pc;
      bit hold, lu;
      #2;
      lu   = model_load_use();
      hold = busy ? !pif.mem_resp_valid_i : (pif.mem_req_valid_i && !pif.mem_resp_valid_i);
      e_if = 0; e_id = 0; e_ex = 0; e_wb = 0; e_pc = 1;
      if (hold) begin
         e_if = 1; e_id = 1; e_ex = 1; e_wb = 2; e_pc = 0;
      end else if (flushing) begin
         e_if = 2;
      end else if (!busy && pif.ex_branch_taken_i) begin
         e_if = 2; e_id = 2;
      end else if (!busy && lu) begin
         e_if = 1; e_id = 2; e_pc = 0;
      end
      chk("if_id",  int'(pif.if_id_ctrl_o),  e_if);
      chk("id_ex",  int'(pif.id_ex_ctrl_o),  e_id);
      chk("ex_mem", int'(pif.ex_mem_ctrl_o), e_ex);
      chk("mem_wb", int'(pif.mem_wb_ctrl_o), e_wb);
      chk("pc_wen", int'(pif.pc_wen_o),      e_pc);
      chk("stall_cnt", int'(stall_cnt),      stalls);
      chk("timeout",   int'(mem_timeout),    int'(tmo));
      if (e_pc == 0 && stalls < SAT) stalls++;
      if (busy && hold) begin
         waited++;
         if (waited >= TMO) tmo = 1'b1;
      end else begin
         waited = 0;
      end
      if (hold) begin
         busy = 1'b1; flushing = 1'b0;
      end else if (busy) begin
         busy = 1'b0;
      end else if (flushing) begin
         flushing = 1'b0;
      end else if (pif.ex_branch_taken_i) begin
         flushing = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      chk("rst_if_id",  int'(pif.if_id_ctrl_o),  2);
      chk("rst_id_ex",  int'(pif.id_ex_ctrl_o),  2);
      chk("rst_ex_mem", int'(pif.ex_mem_ctrl_o), 2);
      chk("rst_mem_wb", int'(pif.mem_wb_ctrl_o), 2);
      chk("rst_pc_wen", int'(pif.pc_wen_o),      0);
      chk("rst_cnt",    int'(stall_cnt),         0);
      chk("rst_tmo",    int'(mem_timeout),       0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      busy = 0; flushing = 0; waited = 0; stalls = 0; tmo = 0;
   endtask

   int base;

   initial begin
      rst = 1'b1;
      quiet();
      #1;
      do_reset();

      // load-use on rs2, then the load moves on
      drive(0, 0, 0, 1, 5'd5, 1, 5'd1, 5'd5, 1, 1);
      step();
      quiet();
      step();
      chk("lu_cnt", int'(stall_cnt), 1);
      // load to x0 never stalls
      drive(0, 0, 0, 1, 5'd0, 1, 5'd0, 5'd0, 1, 1);
      step();
      chk("lu_x0_cnt", int'(stall_cnt), 1);

      // branch pulse then flush cycle
      drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
      step();
      quiet();
      repeat (2) step();

      // four-cycle memory wait
      base = int'(stall_cnt);
      drive(0, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
      repeat (4) step();
      pif.mem_resp_valid_i = 1'b1;
      step();
      chk("memwait_cnt", int'(stall_cnt) - base, 4);

      // mem stall + branch + load-use together, branch held until the response
      drive(1, 1, 0, 1, 5'd3, 1, 5'd3, 5'd0, 1, 0);
      repeat (2) step();
      pif.mem_resp_valid_i = 1'b1;
      step();
      drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
      step();
      quiet();
      repeat (2) step();

      // reset asserted in the middle of a memory wait
      drive(0, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
      repeat (3) step();
      do_reset();
      quiet();
      step();

      // timeout: response withheld for ten cycles
      drive(0, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
      repeat (10) step();
      pif.mem_resp_valid_i = 1'b1;
      step();
      quiet();
      step();
      chk("tmo_sticky", int'(mem_timeout), 1);
      do_reset();
      chk("tmo_cleared", int'(mem_timeout), 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         step();
      end

      // long wait to drive the stall counter into saturation
      drive(0, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
      repeat (SAT + 8) step();
      pif.mem_resp_valid_i = 1'b1;
      step();
      chk("cnt_sat", int'(stall_cnt), SAT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard/stall controller for the 5-stage core.
- Drives the per-stage ctrl_signal inputs of IF_ID, ID_EX, EX_MEM and MEM_WB (Default / Block / Bubble), plus the PC write enable.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Counts stall cycles and flags a hung memory handshake.

Parameters:
- MEM_TIMEOUT, 256, max cycles in MEM_WAIT before mem_timeout_o sets.
- CNT_W, 32, width of stall_cnt_o.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1_addr_i  in  5  rs1 of instruction in ID.
- id_rs2_addr_i  in  5  rs2 of instruction in ID.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_opcode_i  in  7  opcode currently in EX (ID_EX output).
- ex_rd_addr_i  in  5  rd in EX.
- ex_wreg_i  in  1  EX writes rd.
- ex_branch_taken_i  in  1  EX resolved a taken branch/jump (1-cycle pulse).
- mem_req_valid_i  in  1  MEM stage issuing a load/store this cycle.
- mem_resp_valid_i  in  1  data memory returned data / accepted store.
- if_id_ctrl_o  out  2  CTRL_STATE for IF_ID.
- id_ex_ctrl_o  out  2  CTRL_STATE for ID_EX.
- ex_mem_ctrl_o  out  2  CTRL_STATE for EX_MEM.
- mem_wb_ctrl_o  out  2  CTRL_STATE for MEM_WB.
- pc_wen_o  out  1  PC register write enable.
- stall_cnt_o  out  CNT_W  cycles with pc_wen_o=0 since reset, saturating.
- mem_timeout_o  out  1  sticky: a memory wait exceeded MEM_TIMEOUT.

Behaviour:
- Encoding (shared): Default=2'b00, Block=2'b01, Bubble=2'b10.
- Reset (rst=0, immediate, asynchronous):
  - state=RUN, wait counter=0, stall_cnt_o=0, mem_timeout_o=0.
  - All four ctrl outputs=Bubble; pc_wen_o=0.
- Outputs are combinational from state and inputs; state updates on the clock edge.
- States:
  - RUN: normal issue.
  - MEM_WAIT: memory access outstanding.
  - FLUSH: one cycle after a taken branch.
- load_use = (ex_opcode_i==Opcode_Load) & ex_wreg_i & (ex_rd_addr_i!=0) & ((id_use_rs1_i & id_rs1_addr_i==ex_rd_addr_i) | (id_use_rs2_i & id_rs2_addr_i==ex_rd_addr_i)).
- mem_stall = mem_req_valid_i & ~mem_resp_valid_i.
- Priority in RUN, highest first:
  1. mem_stall:
     - IF_ID, ID_EX, EX_MEM = Block; MEM_WB = Bubble; pc_wen=0.
     - Next state MEM_WAIT.
     - Overrides a simultaneous branch or load-use; these are re-evaluated once the memory access completes.
  2. ex_branch_taken_i:
     - IF_ID = Bubble, ID_EX = Bubble; EX_MEM, MEM_WB = Default; pc_wen=1 (branch target loaded).
     - Next state FLUSH.
  3. load_use:
     - IF_ID = Block, ID_EX = Bubble, others Default; pc_wen=0.
     - Stay in RUN. Exactly one bubble results because the load leaves EX on the next edge.
  4. Otherwise: all Default, pc_wen=1.
- MEM_WAIT:
  - Holds the mem_stall outputs while mem_resp_valid_i=0.
  - On mem_resp_valid_i=1: outputs all Default, pc_wen=1, next state RUN.
  - Counts cycles in the state. When the count reaches MEM_TIMEOUT, mem_timeout_o sets and stays set until reset. The stall itself continues regardless.
- FLUSH:
  - IF_ID = Bubble (kills the wrong-path fetch still in IF); others Default; pc_wen=1.
  - Next state RUN, unless mem_stall is asserted this cycle, in which case MEM_WAIT with the mem_stall outputs.
- Load-use and branch in the same cycle: the branch wins; the ID instruction is flushed, so no bubble is needed.
- rd=x0 never causes a load-use stall.
- stall_cnt_o increments on every cycle with pc_wen_o=0 and rst=1. It saturates at all-ones and does not wrap.

Decomposition:
- Shared defines (existing include):
  - CTRL_STATE_Default/Block/Bubble and CTRL_Wire_Bus [1:0].
  - Opcode_Load.
  - New state encodings PCTRL_RUN / PCTRL_MEM_WAIT / PCTRL_FLUSH.
- One natural sub-module, hazard_detect: purely combinational load_use compare, reusable later for a CSR hazard check.
- State flops and counters use the codebase Reg primitive with an asynchronous active-low reset variant.

Test Plan:
- Reset: hold rst=0 mid-MEM_WAIT, then release → all ctrl=2'b10, pc_wen_o=0, stall_cnt_o=0 during reset; all 2'b00, pc_wen=1 on the first cycle after release.
- Load-use: ex_opcode=Load, ex_rd=5, ex_wreg=1, id_rs2=5, id_use_rs2=1 → one cycle IF_ID=01, ID_EX=10, pc_wen=0; next cycle (ex_opcode=addi) all 00; stall_cnt=1. Same stimulus with ex_rd=0 → no stall.
- Branch: ex_branch_taken=1 for one cycle → IF_ID=10, ID_EX=10, pc_wen=1; next cycle IF_ID=10 only; then all 00.
- Memory wait: mem_req_valid=1 with mem_resp_valid=0 for 4 cycles, then 1 → 4 cycles of IF_ID/ID_EX/EX_MEM=01, MEM_WB=10, pc_wen=0; then all 00; stall_cnt=4.
- Simultaneous events: mem_stall + branch + load_use in the same cycle → mem_stall outputs; after the response, branch flush proceeds (branch held by EX via Block).
- Timeout: MEM_TIMEOUT=8, resp withheld for 10 cycles → mem_timeout_o rises after the 8th wait cycle and stays 1 after the response, until rst=0.
